flt_cmd_cfg: RTL and testbench
==============================

FLT_CMD_CFG -- requirements
Module: flt_cmd_cfg

Interface
REQ-001 SHALL have parameters: FAST_SIM, default 1, selects short spin-up timer; DATA_W, default 16, setpoint width; THRST_W, default 9, thrust width; WDOG_W, default 20, link-loss watchdog width; RAMP_DIV_W, default 8, emergency ramp interval width; RAMP_STEP, default 4, thrust decrement per interval.
REQ-002 SHALL have ports: clk in 1, sole clock; rst in 1, reset that is synchronous and active-high.
REQ-003 SHALL have ports: cmd_rdy in 1, command valid; cmd in 8, opcode; data in DATA_W, command payload; cal_done in 1, inertial calibration finished.
REQ-004 SHALL have ports: clr_cmd_rdy out 1, command consumed; resp out 8, response byte; send_resp out 1, response strobe.
REQ-005 SHALL have ports: d_ptch, d_roll, d_yaw out DATA_W signed, desired attitude; thrst out THRST_W unsigned, thrust.
REQ-006 SHALL have ports: strt_cal out 1, calibration start pulse; inertial_cal out 1, calibration in progress; motors_off out 1, motors disabled; emer_active out 1, emergency descent active; link_lost out 1, watchdog tripped.

Function
REQ-007 SHALL decode opcodes: 0x02 pitch, 0x03 roll, 0x04 yaw, 0x05 thrust, 0x06 calibrate, 0x07 emergency land, 0x08 motors off. Every other opcode SHALL be NACKed.
REQ-008 SHALL implement the FSM IDLE -> DECODE -> {RESP | CAL_SPIN}; CAL_SPIN -> CAL_WAIT -> RESP; RESP -> IDLE.
REQ-009 IDLE SHALL go to DECODE when cmd_rdy=1. DECODE SHALL pulse clr_cmd_rdy for exactly 1 cycle.
REQ-010 RESP SHALL pulse send_resp for 1 cycle. resp SHALL be 0xA5 (ACK) or 0xEE (NACK) and SHALL be held stable until the next RESP.
REQ-011 Setpoint writes SHALL take effect in the DECODE cycle, so the register updates on the following edge. Command-to-send_resp latency SHALL be 3 cycles for non-calibrate opcodes.
REQ-012 SET_THRST SHALL saturate: when data > 2^THRST_W-1, thrst = 2^THRST_W-1; otherwise thrst = data[THRST_W-1:0].
REQ-013 CALIBRATE SHALL:
  - set inertial_cal=1, clear the spin-up timer and clear motors_off;
  - in CAL_SPIN, wait until the timer is all ones; the timer width is 9 bits when FAST_SIM=1 and 26 bits otherwise;
  - pulse strt_cal for 1 cycle on entry to CAL_WAIT;
  - in CAL_WAIT, on cal_done clear inertial_cal and go to RESP with ACK.
REQ-014 CALIBRATE SHALL also zero all setpoints, clear emer_active and clear link_lost.
REQ-015 EMER_LAND SHALL zero d_ptch, d_roll and d_yaw immediately and set emer_active. While emer_active, thrst SHALL decrease by RAMP_STEP every 2^RAMP_DIV_W cycles, floored at 0.
REQ-016 When thrst reaches 0 while emer_active, the block SHALL set motors_off=1 and clear emer_active on the next cycle.
REQ-017 While emer_active, opcodes 0x02-0x05 SHALL be NACKed with no register change. 0x06, 0x07 and 0x08 SHALL be accepted.
REQ-018 MTRS_OFF SHALL set motors_off=1, thrst=0 and clear emer_active.
REQ-019 The watchdog counter SHALL clear on every DECODE and increment otherwise, saturating at all ones.
REQ-020 A watchdog trip SHALL occur when the counter reaches all ones while motors_off=0 and inertial_cal=0. A trip SHALL set link_lost and start an emergency land with no response sent.
REQ-021 If a trip and DECODE coincide, DECODE SHALL win and no trip occurs.
REQ-022 cmd_rdy asserted outside IDLE SHALL be ignored until the FSM returns to IDLE; cmd_rdy held high causes back-to-back processing.

Reset
REQ-023 When rst=1 at a clk edge:
  - FSM SHALL go to IDLE;
  - d_ptch, d_roll, d_yaw, thrst SHALL be 0;
  - motors_off SHALL be 1;
  - inertial_cal, strt_cal, send_resp, clr_cmd_rdy, emer_active, link_lost SHALL be 0;
  - resp SHALL be 0xA5;
  - all timers SHALL be 0.
REQ-024 rst asserted mid-calibration or mid-ramp SHALL abort the operation with no response sent.

Structure
REQ-025 Package flt_cmd_pkg SHALL hold: the opcode localparams, RESP_ACK=0xA5, RESP_NACK=0xEE, and the state enum typedef.
REQ-026 The emergency ramp (interval counter plus saturating decrement) SHALL be the sub-module thrst_ramp.

Verification
REQ-027 SET_THRST data=0x0300 with THRST_W=9 -> thrst=0x1FF, resp=0xA5, send_resp exactly 3 cycles after cmd_rdy.
REQ-028 CALIBRATE with FAST_SIM=1:
  - strt_cal pulses once, 512 cycles after DECODE;
  - cal_done 20 cycles later -> ACK, inertial_cal=0, motors_off=0.
REQ-029 thrst=100, then EMER_LAND -> attitudes 0 next cycle; thrst steps 100, 96, ... 0 at 256-cycle intervals; then motors_off=1 and emer_active=0.
REQ-030 During emer_active, SET_PITCH data=0x0010 -> resp=0xEE and d_ptch stays 0. Opcode 0x55 -> resp=0xEE.
REQ-031 With motors on, WDOG_W=8 and no commands for 255 cycles -> link_lost=1, emer_active=1, send_resp stays 0.
REQ-032 rst pulsed during CAL_WAIT -> all outputs at reset values on the next edge; strt_cal and send_resp do not pulse.

Source files
------------

// File: rtl/flt_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flt_cmd_pkg
//  Description : Shared definitions for the flight command/configuration
//                block: opcodes, response bytes and the command FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package flt_cmd_pkg;

    // Command opcodes
    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    // Response bytes
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'hEE;

    // Command FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_RESP     = 3'd2,
        ST_CAL_SPIN = 3'd3,
        ST_CAL_WAIT = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/thrst_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : thrst_ramp
//  Description : Emergency-descent thrust ramp. An interval counter runs
//                while en is high; step marks the last cycle of each
//                2^RAMP_DIV_W-cycle interval. thrst_nxt is the current thrust
//                reduced by RAMP_STEP, floored at zero.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                en              - ramp running (emergency active)
//                thrst_cur       - present thrust value
//                step            - interval elapsed, apply thrst_nxt
//                thrst_nxt       - decremented, floored thrust
//  Revision    : 1.0 - initial release
// ============================================================================
module thrst_ramp #(
    parameter int THRST_W    = 9,
    parameter int RAMP_DIV_W = 8,
    parameter int RAMP_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [THRST_W-1:0] thrst_cur,
    output logic               step,
    output logic [THRST_W-1:0] thrst_nxt
);

    localparam logic [THRST_W-1:0] STEP_V = THRST_W'(RAMP_STEP);

    logic [RAMP_DIV_W-1:0] div_q;
    logic [RAMP_DIV_W-1:0] div_d;

    // Counter restarts from zero every time the ramp is (re)enabled
    always_comb begin
        div_d = en ? div_q + RAMP_DIV_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign step      = en && (div_q == '1);
    assign thrst_nxt = (thrst_cur > STEP_V) ? (thrst_cur - STEP_V) : '0;

endmodule
`default_nettype wire

// File: rtl/flt_cmd_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : flt_cmd_cfg
//  Description : Flight command decoder. Accepts opcode/payload commands,
//                maintains attitude/thrust setpoints, sequences inertial
//                calibration, runs an emergency descent ramp and a link-loss
//                watchdog, and returns an ACK/NACK byte per command.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                cmd_rdy, cmd, data       - command valid, opcode, payload
//                cal_done                 - inertial calibration finished
//                clr_cmd_rdy              - command consumed (1-cycle pulse)
//                resp, send_resp          - response byte and its strobe
//                d_ptch, d_roll, d_yaw    - signed attitude setpoints
//                thrst                    - unsigned thrust setpoint
//                strt_cal, inertial_cal   - calibration start / in progress
//                motors_off, emer_active  - motor disable / emergency descent
//                link_lost                - watchdog tripped
//  Revision    : 1.0 - initial release
// ============================================================================
module flt_cmd_cfg
    import flt_cmd_pkg::*;
#(
    parameter int FAST_SIM   = 1,
    parameter int DATA_W     = 16,
    parameter int THRST_W    = 9,
    parameter int WDOG_W     = 20,
    parameter int RAMP_DIV_W = 8,
    parameter int RAMP_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_rdy,
    input  logic [7:0]               cmd,
    input  logic [DATA_W-1:0]        data,
    input  logic                     cal_done,
    output logic                     clr_cmd_rdy,
    output logic [7:0]               resp,
    output logic                     send_resp,
    output logic signed [DATA_W-1:0] d_ptch,
    output logic signed [DATA_W-1:0] d_roll,
    output logic signed [DATA_W-1:0] d_yaw,
    output logic [THRST_W-1:0]       thrst,
    output logic                     strt_cal,
    output logic                     inertial_cal,
    output logic                     motors_off,
    output logic                     emer_active,
    output logic                     link_lost
);

    localparam int                 SPIN_W      = (FAST_SIM != 0) ? 9 : 26;
    localparam logic [DATA_W-1:0]  THRST_MAX_D = DATA_W'((2 ** THRST_W) - 1);
    localparam logic [WDOG_W-1:0]  WDOG_PRE    = {{(WDOG_W-1){1'b1}}, 1'b0};

    state_e                     state_q, state_d;
    logic signed [DATA_W-1:0]   d_ptch_q, d_ptch_d;
    logic signed [DATA_W-1:0]   d_roll_q, d_roll_d;
    logic signed [DATA_W-1:0]   d_yaw_q, d_yaw_d;
    logic [THRST_W-1:0]         thrst_q, thrst_d;
    logic [SPIN_W-1:0]          spin_q, spin_d;
    logic [WDOG_W-1:0]          wdog_q, wdog_d;
    logic [7:0]                 resp_q, resp_d;
    logic [7:0]                 pend_q, pend_d;
    logic                       send_resp_q, send_resp_d;
    logic                       clr_cmd_rdy_q, clr_cmd_rdy_d;
    logic                       strt_cal_q, strt_cal_d;
    logic                       inertial_cal_q, inertial_cal_d;
    logic                       motors_off_q, motors_off_d;
    logic                       emer_active_q, emer_active_d;
    logic                       link_lost_q, link_lost_d;

    logic                       ramp_step;
    logic [THRST_W-1:0]         ramp_thrst;
    logic                       wdog_trip;

    thrst_ramp #(
        .THRST_W    (THRST_W),
        .RAMP_DIV_W (RAMP_DIV_W),
        .RAMP_STEP  (RAMP_STEP)
    ) u_thrst_ramp (
        .clk       (clk),
        .rst       (rst),
        .en        (emer_active_q),
        .thrst_cur (thrst_q),
        .step      (ramp_step),
        .thrst_nxt (ramp_thrst)
    );

    // Trip on the cycle the counter steps onto all ones. A counter that
    // saturated during calibration therefore cannot fire the instant the
    // calibration ends; a DECODE in the same cycle always wins.
    assign wdog_trip = (wdog_q == WDOG_PRE) && !motors_off_q && !inertial_cal_q &&
                       (state_q != ST_DECODE);

    always_comb begin
        state_d        = state_q;
        d_ptch_d       = d_ptch_q;
        d_roll_d       = d_roll_q;
        d_yaw_d        = d_yaw_q;
        thrst_d        = thrst_q;
        spin_d         = spin_q;
        wdog_d         = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
        resp_d         = resp_q;
        pend_d         = pend_q;
        send_resp_d    = 1'b0;
        clr_cmd_rdy_d  = 1'b0;
        strt_cal_d     = 1'b0;
        inertial_cal_d = inertial_cal_q;
        motors_off_d   = motors_off_q;
        emer_active_d  = emer_active_q;
        link_lost_d    = link_lost_q;

        if (wdog_trip) begin
            link_lost_d   = 1'b1;
            emer_active_d = 1'b1;
            d_ptch_d      = '0;
            d_roll_d      = '0;
            d_yaw_d       = '0;
        end

        // Descent finished: cut motors and leave emergency mode
        if (emer_active_q) begin
            if (thrst_q == '0) begin
                motors_off_d  = 1'b1;
                emer_active_d = 1'b0;
            end else if (ramp_step) begin
                thrst_d = ramp_thrst;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_rdy) begin
                    state_d       = ST_DECODE;
                    clr_cmd_rdy_d = 1'b1;
                end
            end
            ST_DECODE: begin
                wdog_d  = '0;
                pend_d  = RESP_ACK;
                state_d = ST_RESP;
                case (cmd)
                    OP_SET_PTCH: begin
                        if (emer_active_q) pend_d = RESP_NACK;
                        else               d_ptch_d = $signed(data);
                    end
                    OP_SET_ROLL: begin
                        if (emer_active_q) pend_d = RESP_NACK;
                        else               d_roll_d = $signed(data);
                    end
                    OP_SET_YAW: begin
                        if (emer_active_q) pend_d = RESP_NACK;
                        else               d_yaw_d = $signed(data);
                    end
                    OP_SET_THRST: begin
                        if (emer_active_q)            pend_d  = RESP_NACK;
                        else if (data > THRST_MAX_D)  thrst_d = '1;
                        else                          thrst_d = data[THRST_W-1:0];
                    end
                    OP_CALIBRATE: begin
                        inertial_cal_d = 1'b1;
                        spin_d         = '0;
                        motors_off_d   = 1'b0;
                        emer_active_d  = 1'b0;
                        link_lost_d    = 1'b0;
                        d_ptch_d       = '0;
                        d_roll_d       = '0;
                        d_yaw_d        = '0;
                        thrst_d        = '0;
                        state_d        = ST_CAL_SPIN;
                    end
                    OP_EMER_LAND: begin
                        d_ptch_d      = '0;
                        d_roll_d      = '0;
                        d_yaw_d       = '0;
                        emer_active_d = 1'b1;
                    end
                    OP_MTRS_OFF: begin
                        motors_off_d  = 1'b1;
                        thrst_d       = '0;
                        emer_active_d = 1'b0;
                    end
                    default: pend_d = RESP_NACK;
                endcase
            end
            ST_CAL_SPIN: begin
                // Leave as the timer becomes all ones, so strt_cal appears
                // exactly 2^SPIN_W cycles after the DECODE cycle.
                spin_d = spin_q + SPIN_W'(1);
                if (spin_d == '1) begin
                    state_d    = ST_CAL_WAIT;
                    strt_cal_d = 1'b1;
                end
            end
            ST_CAL_WAIT: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    pend_d         = RESP_ACK;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                send_resp_d = 1'b1;
                resp_d      = pend_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            d_ptch_q       <= '0;
            d_roll_q       <= '0;
            d_yaw_q        <= '0;
            thrst_q        <= '0;
            spin_q         <= '0;
            wdog_q         <= '0;
            resp_q         <= RESP_ACK;
            pend_q         <= RESP_ACK;
            send_resp_q    <= 1'b0;
            clr_cmd_rdy_q  <= 1'b0;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            motors_off_q   <= 1'b1;
            emer_active_q  <= 1'b0;
            link_lost_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_ptch_q       <= d_ptch_d;
            d_roll_q       <= d_roll_d;
            d_yaw_q        <= d_yaw_d;
            thrst_q        <= thrst_d;
            spin_q         <= spin_d;
            wdog_q         <= wdog_d;
            resp_q         <= resp_d;
            pend_q         <= pend_d;
            send_resp_q    <= send_resp_d;
            clr_cmd_rdy_q  <= clr_cmd_rdy_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
            motors_off_q   <= motors_off_d;
            emer_active_q  <= emer_active_d;
            link_lost_q    <= link_lost_d;
        end
    end

    assign clr_cmd_rdy  = clr_cmd_rdy_q;
    assign resp         = resp_q;
    assign send_resp    = send_resp_q;
    assign d_ptch       = d_ptch_q;
    assign d_roll       = d_roll_q;
    assign d_yaw        = d_yaw_q;
    assign thrst        = thrst_q;
    assign strt_cal     = strt_cal_q;
    assign inertial_cal = inertial_cal_q;
    assign motors_off   = motors_off_q;
    assign emer_active  = emer_active_q;
    assign link_lost    = link_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_flt_cmd_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flt_cmd_cfg
//  Description : Self-checking bench for flt_cmd_cfg. Expected response bytes
//                are queued when a command is issued and compared when the
//                DUT strobes send_resp.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flt_cmd_cfg;
    import flt_cmd_pkg::*;

    localparam int DATA_W  = 16;
    localparam int THRST_W = 9;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cmd_rdy = 1'b0;
    logic [7:0]               cmd = 8'h00;
    logic [DATA_W-1:0]        data = '0;
    logic                     cal_done = 1'b0;
    logic                     clr_cmd_rdy;
    logic [7:0]               resp;
    logic                     send_resp;
    logic signed [DATA_W-1:0] d_ptch, d_roll, d_yaw;
    logic [THRST_W-1:0]       thrst;
    logic                     strt_cal, inertial_cal, motors_off, emer_active, link_lost;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_send = 0;
    int         n_strt = 0;
    logic [7:0] exp_q[$];

    flt_cmd_cfg #(
        .FAST_SIM   (1),
        .DATA_W     (DATA_W),
        .THRST_W    (THRST_W),
        .WDOG_W     (8),
        .RAMP_DIV_W (8),
        .RAMP_STEP  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .cal_done     (cal_done),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .motors_off   (motors_off),
        .emer_active  (emer_active),
        .link_lost    (link_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every send_resp consumes one queued expectation
    always @(negedge clk) begin
        if (send_resp) begin
            n_send <= n_send + 1;
            if (exp_q.size() == 0) chk("resp_unexpected", exp_q.size(), 1);
            else                   chk("resp", {24'd0, resp}, {24'd0, exp_q.pop_front()});
        end
        if (strt_cal) n_strt <= n_strt + 1;
    end

    // Present a command and wait for it to be consumed
    task automatic issue(input logic [7:0] op, input logic [15:0] d, input logic push,
                         input logic [7:0] exp_r, output int t_iss, output int t_dec);
        int k;
        if (push) exp_q.push_back(exp_r);
        @(negedge clk);
        cmd     = op;
        data    = d;
        cmd_rdy = 1'b1;
        t_iss   = cyc;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clr_cmd_rdy && k < 20);
        chk("clr_cmd_rdy_lat", cyc - t_iss, 1);
        t_dec   = cyc;
        cmd_rdy = 1'b0;
    endtask

    // Non-calibrate command: response expected 3 cycles after cmd_rdy
    task automatic do_cmd(input logic [7:0] op, input logic [15:0] d, input logic [7:0] exp_r);
        int t_iss, t_dec, k;
        issue(op, d, 1'b1, exp_r, t_iss, t_dec);
        k = 0;
        while (!send_resp && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("resp_latency", cyc - t_iss, 3);
        @(negedge clk);
        chk("clr_single", {31'd0, clr_cmd_rdy}, 0);
    endtask

    // Calibrate with cal_done 20 cycles after strt_cal
    task automatic do_cal();
        int t_iss, t_dec, t_s, k;
        issue(OP_CALIBRATE, 16'h0000, 1'b1, RESP_ACK, t_iss, t_dec);
        k = 0;
        while (!strt_cal && k < 600) begin
            @(negedge clk);
            k++;
        end
        t_s = cyc;
        chk("strt_cal_delay", t_s - t_dec, 512);
        chk("inertial_cal_busy", {31'd0, inertial_cal}, 1);
        repeat (19) @(negedge clk);
        chk("strt_cal_once", {31'd0, strt_cal}, 0);
        @(negedge clk);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        k = 0;
        while (!send_resp && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("cal_resp_seen", {31'd0, send_resp}, 1);
        chk("cal_inertial_clr", {31'd0, inertial_cal}, 0);
        chk("cal_motors_on", {31'd0, motors_off}, 0);
    endtask

    initial begin
        int t_iss, t_dec, t_emer, t_prev, prev, k, snap_send, snap_strt;

        repeat (3) @(negedge clk);
        chk("rst_thrst", {23'd0, thrst}, 0);
        chk("rst_ptch", {16'd0, d_ptch}, 0);
        chk("rst_motors_off", {31'd0, motors_off}, 1);
        chk("rst_resp", {24'd0, resp}, 32'hA5);
        chk("rst_flags", {27'd0, send_resp, clr_cmd_rdy, strt_cal, emer_active, link_lost}, 0);
        rst = 1'b0;

        // Thrust saturation and boundary
        do_cmd(OP_SET_THRST, 16'h0300, RESP_ACK);
        chk("thrst_sat", {23'd0, thrst}, 32'h1FF);
        do_cmd(OP_SET_THRST, 16'h00FF, RESP_ACK);
        chk("thrst_ff", {23'd0, thrst}, 32'h0FF);
        do_cmd(OP_SET_THRST, 16'h0200, RESP_ACK);
        chk("thrst_200", {23'd0, thrst}, 32'h1FF);

        // Attitude setpoints
        do_cmd(OP_SET_PTCH, 16'h1234, RESP_ACK);
        do_cmd(OP_SET_ROLL, 16'hFF80, RESP_ACK);
        do_cmd(OP_SET_YAW, 16'h7FFF, RESP_ACK);
        chk("ptch", {16'd0, d_ptch}, 32'h1234);
        chk("roll", {16'd0, d_roll}, 32'hFF80);
        chk("yaw", {16'd0, d_yaw}, 32'h7FFF);

        // Unknown opcodes, response held afterwards
        do_cmd(8'h55, 16'h0001, RESP_NACK);
        do_cmd(8'h00, 16'h0001, RESP_NACK);
        repeat (5) @(negedge clk);
        chk("resp_held", {24'd0, resp}, 32'hEE);
        chk("ptch_kept", {16'd0, d_ptch}, 32'h1234);

        // Motors off
        do_cmd(OP_MTRS_OFF, 16'h0000, RESP_ACK);
        chk("mtrs_off", {31'd0, motors_off}, 1);
        chk("mtrs_off_thrst", {23'd0, thrst}, 0);

        // Calibration zeroes setpoints and enables motors
        do_cmd(OP_SET_PTCH, 16'h0042, RESP_ACK);
        do_cal();
        chk("cal_ptch_zero", {16'd0, d_ptch}, 0);
        chk("cal_yaw_zero", {16'd0, d_yaw}, 0);

        // Watchdog trip after a silent link
        snap_send = n_send;
        issue(OP_SET_PTCH, 16'h0010, 1'b1, RESP_ACK, t_iss, t_dec);
        repeat (4) @(negedge clk);
        snap_send = n_send;
        chk("wdog_ptch_set", {16'd0, d_ptch}, 32'h0010);
        k = 0;
        while (!link_lost && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wdog_link_lost", {31'd0, link_lost}, 1);
        chk("wdog_window", {31'd0, ((cyc - t_dec) >= 255) && ((cyc - t_dec) <= 257)}, 1);
        chk("wdog_emer", {31'd0, emer_active}, 1);
        chk("wdog_ptch_zero", {16'd0, d_ptch}, 0);
        chk("wdog_no_resp", n_send, snap_send);
        repeat (3) @(negedge clk);
        chk("wdog_motors_off", {31'd0, motors_off}, 1);
        chk("wdog_emer_done", {31'd0, emer_active}, 0);

        // Recalibrate, then emergency land from thrust 100
        do_cal();
        chk("cal_link_clr", {31'd0, link_lost}, 0);
        do_cmd(OP_SET_THRST, 16'd100, RESP_ACK);
        do_cmd(OP_SET_PTCH, 16'h0020, RESP_ACK);
        issue(OP_EMER_LAND, 16'h0000, 1'b1, RESP_ACK, t_iss, t_dec);
        @(negedge clk);
        t_emer = cyc;
        chk("emer_ptch_zero", {16'd0, d_ptch}, 0);
        chk("emer_active", {31'd0, emer_active}, 1);
        do_cmd(OP_SET_PTCH, 16'h0010, RESP_NACK);
        chk("emer_ptch_locked", {16'd0, d_ptch}, 0);
        do_cmd(8'h55, 16'h0000, RESP_NACK);
        chk("emer_thrst_hold", {23'd0, thrst}, 32'd100);

        prev   = 100;
        t_prev = t_emer;
        for (int s = 0; s < 25; s++) begin
            k = 0;
            while (int'(thrst) == prev && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("ramp_val", {23'd0, thrst}, prev - 4);
            chk("ramp_interval", cyc - t_prev, 256);
            prev   = int'(thrst);
            t_prev = cyc;
        end
        @(negedge clk);
        chk("ramp_motors_off", {31'd0, motors_off}, 1);
        chk("ramp_emer_clr", {31'd0, emer_active}, 0);

        // Reset in the middle of calibration
        issue(OP_CALIBRATE, 16'h0000, 1'b0, RESP_ACK, t_iss, t_dec);
        k = 0;
        while (!strt_cal && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        snap_send = n_send;
        snap_strt = n_strt;
        rst = 1'b1;
        @(negedge clk);
        chk("rstcal_inertial", {31'd0, inertial_cal}, 0);
        chk("rstcal_motors_off", {31'd0, motors_off}, 1);
        chk("rstcal_resp", {24'd0, resp}, 32'hA5);
        chk("rstcal_flags", {27'd0, send_resp, clr_cmd_rdy, strt_cal, emer_active, link_lost}, 0);
        rst = 1'b0;
        cal_done = 1'b1;
        repeat (40) @(negedge clk);
        cal_done = 1'b0;
        chk("rstcal_no_send", n_send, snap_send);
        chk("rstcal_no_strt", n_strt, snap_strt);
        do_cmd(OP_SET_THRST, 16'h0005, RESP_ACK);
        chk("post_rst_thrst", {23'd0, thrst}, 32'd5);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
